// File: rtl/traffic_ctrl.sv
// Two-way intersection phase sequencer: light phases, per-direction countdowns
// and display enable, with pedestrian shortening, emergency all-red and flashing mode.
module traffic_ctrl #(
    parameter int TICK_DIV  = 50,
    parameter int G_MAIN    = 20,
    parameter int G_SIDE    = 15,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int PED_GREEN = 5
) (
    input  logic       clk_divide,
    input  logic       rst_n,
    input  logic       run,
    input  logic       emerg,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [7:0] data,
    output logic [7:0] data2,
    output logic       seg_en
);
    typedef enum logic [2:0] {AR2, MG, MY, AR1, SG, SY, FLASH, EMERG} state_t;

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]    D_GM    = 5'(G_MAIN);
    localparam logic [4:0]    D_GS    = 5'(G_SIDE);
    localparam logic [4:0]    D_Y     = 5'(YELLOW);
    localparam logic [4:0]    D_AR    = 5'(ALL_RED);
    localparam logic [4:0]    D_PED   = 5'(PED_GREEN);
    localparam logic [7:0]    GM8     = 8'(G_MAIN);
    localparam logic [7:0]    GS8     = 8'(G_SIDE);
    localparam logic [7:0]    Y8      = 8'(YELLOW);
    localparam logic [7:0]    AR8     = 8'(ALL_RED);

    state_t        r_state, w_state_n, w_adv;
    logic [4:0]    r_cnt, w_cnt_n;
    logic [PW-1:0] r_pre, w_pre_n;
    logic          r_ped, w_ped_n;
    logic          r_blink, w_blink_n;
    logic          w_tick;
    logic [7:0]    w_cnt8;
    logic [2:0]    w_main, w_side;
    logic [7:0]    w_data, w_data2;
    logic          w_en;

    function automatic logic [4:0] dur_of(input state_t s);
        case (s)
            MG:      return D_GM;
            MY:      return D_Y;
            SG:      return D_GS;
            SY:      return D_Y;
            default: return D_AR;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            AR2:     return MG;
            MG:      return MY;
            MY:      return AR1;
            AR1:     return SG;
            SG:      return SY;
            default: return AR2;
        endcase
    endfunction

    assign w_tick = (r_pre == PRE_MAX);
    assign w_adv  = next_of(r_state);
    assign w_cnt8 = {3'b000, r_cnt};

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pre_n   = w_tick ? '0 : r_pre + 1'b1;
        w_blink_n = r_blink;
        w_ped_n   = r_ped | ped_req;
        if (emerg) begin
            w_state_n = EMERG;
        end else if (!run) begin
            w_state_n = FLASH;
            if (r_state != FLASH) begin
                w_pre_n   = '0;
                w_blink_n = 1'b1;
            end else if (w_tick) begin
                w_blink_n = ~r_blink;
            end
        end else if (r_state == FLASH || r_state == EMERG) begin
            w_state_n = AR2;
            w_cnt_n   = D_AR;
            w_pre_n   = '0;
        end else if (w_tick && r_cnt == 5'd1) begin
            w_state_n = w_adv;
            w_cnt_n   = dur_of(w_adv);
            w_pre_n   = '0;
            // A request in the very cycle SG is entered belongs to the next MG.
            if (w_adv == SG) w_ped_n = ped_req;
        end else if (r_state == MG && r_ped && r_cnt > D_PED) begin
            w_cnt_n = D_PED;
        end else if (w_tick) begin
            w_cnt_n = r_cnt - 5'd1;
        end
    end

    always_comb begin
        w_main  = 3'b100;
        w_side  = 3'b100;
        w_data  = w_cnt8;
        w_data2 = w_cnt8;
        w_en    = 1'b1;
        case (r_state)
            MG: begin
                w_main  = 3'b001;
                w_data2 = w_cnt8 + Y8 + AR8;
            end
            MY: begin
                w_main  = 3'b010;
                w_data2 = w_cnt8 + AR8;
            end
            AR1: w_data = w_cnt8 + GS8 + Y8 + AR8;
            SG: begin
                w_side = 3'b001;
                w_data = w_cnt8 + Y8 + AR8;
            end
            SY: begin
                w_side = 3'b010;
                w_data = w_cnt8 + AR8;
            end
            AR2: w_data2 = w_cnt8 + GM8 + Y8 + AR8;
            EMERG: begin
                w_data  = 8'd0;
                w_data2 = 8'd0;
            end
            FLASH: begin
                w_main  = {1'b0, r_blink, 1'b0};
                w_side  = {1'b0, r_blink, 1'b0};
                w_data  = 8'd0;
                w_data2 = 8'd0;
                w_en    = 1'b0;
            end
            default: ;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk_divide or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= AR2;
            r_cnt      <= D_AR;
            r_pre      <= '0;
            r_ped      <= 1'b0;
            r_blink    <= 1'b1;
            main_light <= 3'b100;
            side_light <= 3'b100;
            data       <= 8'd0;
            data2      <= 8'd0;
            seg_en     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_pre      <= w_pre_n;
            r_ped      <= w_ped_n;
            r_blink    <= w_blink_n;
            main_light <= w_main;
            side_light <= w_side;
            data       <= w_data;
            data2      <= w_data2;
            seg_en     <= w_en;
        end
    end
endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: hand-derived vector table, a time-based reference model
// checked every cycle under random stimulus, and emergency / async-reset sequences.
module tb_traffic_ctrl;
    localparam int TD = 4, GM = 20, GS = 15, YL = 3, AR = 2, PG = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b1, emerg = 1'b0, ped = 1'b0;
    logic [2:0] ml, sl;
    logic [7:0] d, d2;
    logic       en;

    traffic_ctrl #(.TICK_DIV(TD), .G_MAIN(GM), .G_SIDE(GS), .YELLOW(YL),
                   .ALL_RED(AR), .PED_GREEN(PG)) dut (
        .clk_divide(clk), .rst_n(rst), .run(run), .emerg(emerg), .ped_req(ped),
        .main_light(ml), .side_light(sl), .data(d), .data2(d2), .seg_en(en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [22:0] exp_q[$];

    // Model: phase index 0..5 = AR2,MG,MY,AR1,SG,SY; time kept as cycles left in phase.
    int         m_mode;  // 0 normal, 1 flashing, 2 emergency
    int         m_ph, m_rem, m_fk;
    bit         m_latch;
    int         dur_s[6];
    logic [2:0] ml_t[6], sl_t[6];

    typedef struct {
        bit         r, e, p;
        int         n;
        logic [2:0] ml, sl;
        logic [7:0] d, d2;
        logic       en;
    } vec_t;
    vec_t vt[19];

    function automatic int secs_left();
        return (m_rem + TD - 1) / TD;
    endfunction

    // Seconds until this direction's light next changes (until green when red).
    function automatic int until_change(bit main_dir);
        int s = secs_left();
        int p = (m_ph + 1) % 6;
        logic [2:0] cur = main_dir ? ml_t[m_ph] : sl_t[m_ph];
        while ((main_dir ? ml_t[p] : sl_t[p]) == cur) begin
            s += dur_s[p];
            p = (p + 1) % 6;
        end
        return s;
    endfunction

    function automatic logic [22:0] model_out();
        logic b;
        if (m_mode == 2) return {3'b100, 3'b100, 8'd0, 8'd0, 1'b1};
        if (m_mode == 1) begin
            b = ((m_fk / TD) % 2) == 0;
            return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 16'd0, 1'b0};
        end
        return {ml_t[m_ph], sl_t[m_ph], 8'(until_change(1'b1)), 8'(until_change(1'b0)), 1'b1};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_rem = AR * TD; m_fk = 0; m_latch = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit p);
        bit into_sg = 1'b0;
        int sec = secs_left();
        int rr;
        if (e) m_mode = 2;
        else if (!r) begin
            if (m_mode != 1) begin m_mode = 1; m_fk = 0; end
            else m_fk++;
        end else if (m_mode != 0) begin
            m_mode = 0; m_ph = 0; m_rem = AR * TD;
        end else if (m_rem == 1) begin
            m_ph = (m_ph + 1) % 6;
            m_rem = dur_s[m_ph] * TD;
            into_sg = (m_ph == 4);
        end else if (m_ph == 1 && m_latch && sec > PG) begin
            // Current second runs out on schedule, then PG-1 further whole seconds.
            rr = (m_rem - 1) % TD;
            if (rr == 0) rr = TD;
            m_rem = (PG - 1) * TD + rr;
        end else m_rem--;
        m_latch = into_sg ? p : (m_latch | p);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic cycle();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        model_step(run, emerg, ped);
        check("model", {9'd0, ml, sl, d, d2, en}, {9'd0, exp_q.pop_front()});
        check("range", {31'd0, (d <= 8'd30 && d2 <= 8'd30)}, 32'd1);
    endtask

    task automatic wait_model(input int ph, input int secs, input string nm);
        int w = 0;
        while (!(m_mode == 0 && m_ph == ph && (secs < 0 || secs_left() == secs)) && w < 1000) begin
            cycle();
            w++;
        end
        check(nm, {31'd0, (w < 1000)}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, len;
        dur_s = '{AR, GM, YL, AR, GS, YL};
        ml_t  = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
        sl_t  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
        vt[0]  = '{1, 0, 0,  1, 3'b100, 3'b100, 8'd2,  8'd27, 1'b1};
        vt[1]  = '{1, 0, 0,  4, 3'b100, 3'b100, 8'd1,  8'd26, 1'b1};
        vt[2]  = '{1, 0, 0,  4, 3'b001, 3'b100, 8'd20, 8'd25, 1'b1};
        vt[3]  = '{1, 0, 0,  4, 3'b001, 3'b100, 8'd19, 8'd24, 1'b1};
        vt[4]  = '{1, 0, 0, 76, 3'b010, 3'b100, 8'd3,  8'd5,  1'b1};
        vt[5]  = '{1, 0, 0, 12, 3'b100, 3'b100, 8'd22, 8'd2,  1'b1};
        vt[6]  = '{1, 0, 0,  8, 3'b100, 3'b001, 8'd20, 8'd15, 1'b1};
        vt[7]  = '{1, 0, 0, 60, 3'b100, 3'b010, 8'd5,  8'd3,  1'b1};
        vt[8]  = '{1, 0, 0, 12, 3'b100, 3'b100, 8'd2,  8'd27, 1'b1};
        vt[9]  = '{0, 0, 0,  2, 3'b010, 3'b010, 8'd0,  8'd0,  1'b0};
        vt[10] = '{0, 0, 0,  4, 3'b000, 3'b000, 8'd0,  8'd0,  1'b0};
        vt[11] = '{0, 1, 0,  2, 3'b100, 3'b100, 8'd0,  8'd0,  1'b1};
        vt[12] = '{0, 0, 0,  2, 3'b010, 3'b010, 8'd0,  8'd0,  1'b0};
        vt[13] = '{1, 0, 0,  2, 3'b100, 3'b100, 8'd2,  8'd27, 1'b1};
        vt[14] = '{1, 0, 0,  8, 3'b001, 3'b100, 8'd20, 8'd25, 1'b1};
        vt[15] = '{1, 0, 1,  1, 3'b001, 3'b100, 8'd20, 8'd25, 1'b1};
        vt[16] = '{1, 0, 0,  2, 3'b001, 3'b100, 8'd5,  8'd10, 1'b1};
        vt[17] = '{1, 0, 0,  1, 3'b001, 3'b100, 8'd4,  8'd9,  1'b1};
        vt[18] = '{1, 0, 0, 16, 3'b010, 3'b100, 8'd3,  8'd5,  1'b1};

        // Clock/reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b100, 3'b100, 8'd0, 8'd0, 1'b0});
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 19; i++) begin
            run = vt[i].r; emerg = vt[i].e; ped = vt[i].p;
            repeat (vt[i].n) cycle();
            check($sformatf("vec%0d", i), {9'd0, ml, sl, d, d2, en},
                  {9'd0, vt[i].ml, vt[i].sl, vt[i].d, vt[i].d2, vt[i].en});
        end
        ped = 1'b0;

        // Random stimulus against the model
        for (int seg = 0; seg < 120; seg++) begin
            k = $urandom_range(0, 99);
            run   = !(k >= 80 && k < 88) && !(k >= 95);
            emerg = (k >= 88);
            len   = (k < 80) ? $urandom_range(1, 100) : $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                ped = ($urandom_range(0, 24) == 0);
                cycle();
            end
        end
        run = 1'b1; emerg = 1'b0; ped = 1'b0;

        // Emergency during SG at 9 s
        wait_model(4, 9, "reach_sg9");
        emerg = 1'b1;
        repeat (2) cycle();
        check("emerg_on", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b100, 3'b100, 8'd0, 8'd0, 1'b1});
        emerg = 1'b0;
        repeat (2) cycle();
        check("emerg_off", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b100, 3'b100, 8'd2, 8'd27, 1'b1});
        repeat (8) cycle();
        check("emerg_mg", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b001, 3'b100, 8'd20, 8'd25, 1'b1});

        // Async reset between clock edges in SG
        wait_model(4, -1, "reach_sg");
        repeat (3) cycle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b100, 3'b100, 8'd0, 8'd0, 1'b0});
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("restart", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b100, 3'b100, 8'd2, 8'd27, 1'b1});
        repeat (8) cycle();
        check("restart_mg", {9'd0, ml, sl, d, d2, en}, {9'd0, 3'b001, 3'b100, 8'd20, 8'd25, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
